// File: rtl/core_pkg.sv
// Shared core constants and types: the instruction-fetch defaults used by the
// PC unit and the instruction memory, plus the fetch-state encoding.
package core_pkg;

    localparam int unsigned DEF_DATA_W   = 32;
    localparam int unsigned DEF_DEPTH    = 256;
    localparam int unsigned DEF_ADDR_W   = 32;
    // addi x0,x0,0
    localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

endpackage

// File: rtl/inst_mem_array.sv
// Single-write-port, single-synchronous-read-port instruction RAM.
// Ports: clk; we/waddr/wdata write port; re/raddr read request,
// rd_data registered read data (updates only when re is high).
module inst_mem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [IDX_W-1:0]  raddr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Storage is deliberately unreset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rd_data <= mem[raddr];
        end
    end

endmodule

// File: rtl/inst_mem_ctrl.sv
// Instruction memory controller: accepts a boot image as a word stream, then
// serves valid/ready fetches with one-cycle registered latency.
// Ports: clk, rst_n; load_valid/load_ready/load_data/load_last boot stream,
// load_done image-loaded flag; fetch_req_valid/fetch_req_ready/fetch_addr
// request, fetch_flush discard; fetch_rsp_valid/fetch_rsp_ready/fetch_inst/
// fetch_fault response.
module inst_mem_ctrl
    import core_pkg::*;
#(
    parameter int unsigned       DATA_W   = DEF_DATA_W,
    parameter int unsigned       DEPTH    = DEF_DEPTH,
    parameter int unsigned       ADDR_W   = DEF_ADDR_W,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(DEF_NOP_INST)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              load_done,
    input  logic              fetch_req_valid,
    output logic              fetch_req_ready,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_flush,
    output logic              fetch_rsp_valid,
    input  logic              fetch_rsp_ready,
    output logic [DATA_W-1:0] fetch_inst,
    output logic              fetch_fault
);

    localparam int unsigned IDX_W = $clog2(DEPTH);

    fetch_state_e      state_q, state_d;
    logic [IDX_W-1:0]  load_ptr_q, load_ptr_d;
    logic              load_done_q, load_done_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_fault_q, rsp_fault_d;
    logic              rsp_mem_q, rsp_mem_d;

    logic              load_beat;
    logic              fetch_accept;
    logic              misaligned;
    logic              in_range;
    logic [ADDR_W-1:0] fetch_idx;
    logic              mem_we;
    logic              mem_re;
    logic [DATA_W-1:0] mem_rd_data;

    // Handshake decode from registered state.
    assign load_ready      = (state_q == BOOT);
    assign fetch_req_ready = (state_q == RUN) && (!rsp_valid_q || fetch_rsp_ready);
    assign load_beat       = load_valid && load_ready;
    assign fetch_accept    = fetch_req_valid && fetch_req_ready && !fetch_flush;

    // Range check at full address width so idx == DEPTH is out of range.
    assign misaligned = |fetch_addr[1:0];
    assign fetch_idx  = fetch_addr >> 2;
    assign in_range   = fetch_idx < ADDR_W'(DEPTH);

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        load_ptr_d  = load_ptr_q;
        load_done_d = load_done_q;
        rsp_valid_d = rsp_valid_q;
        rsp_fault_d = rsp_fault_q;
        rsp_mem_d   = rsp_mem_q;
        mem_we      = 1'b0;
        mem_re      = 1'b0;

        case (state_q)
            BOOT: begin
                if (load_beat) begin
                    mem_we     = 1'b1;
                    load_ptr_d = load_ptr_q + IDX_W'(1);
                    if (load_last || (load_ptr_q == IDX_W'(DEPTH - 1))) begin
                        state_d     = RUN;
                        load_done_d = 1'b1;
                    end
                end
            end
            RUN: begin
                if (fetch_flush) begin
                    rsp_valid_d = 1'b0;
                end else if (fetch_accept) begin
                    rsp_valid_d = 1'b1;
                    rsp_fault_d = misaligned;
                    // Only touch the RAM for a legal word; rd_data then holds
                    // while the response stalls.
                    rsp_mem_d   = !misaligned && in_range;
                    mem_re      = !misaligned && in_range;
                end else if (fetch_rsp_ready) begin
                    rsp_valid_d = 1'b0;
                end
            end
            default: begin
                state_d = BOOT;
            end
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            load_ptr_q  <= '0;
            load_done_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_fault_q <= 1'b0;
            rsp_mem_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_ptr_q  <= load_ptr_d;
            load_done_q <= load_done_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_fault_q <= rsp_fault_d;
            rsp_mem_q   <= rsp_mem_d;
        end
    end

    inst_mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk     (clk),
        .we      (mem_we),
        .waddr   (load_ptr_q),
        .wdata   (load_data),
        .re      (mem_re),
        .raddr   (fetch_idx[IDX_W-1:0]),
        .rd_data (mem_rd_data)
    );

    // Registered RAM word or the NOP for faulted / out-of-range responses.
    assign fetch_inst      = rsp_mem_q ? mem_rd_data : NOP_INST;
    assign fetch_fault     = rsp_fault_q;
    assign fetch_rsp_valid = rsp_valid_q;
    assign load_done       = load_done_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
// Scoreboard bench for inst_mem_ctrl: stimulus pushes expected responses,
// a negedge monitor pops and compares each accepted response.
module tb_inst_mem_ctrl;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 256;
    localparam int unsigned ADDR_W = 32;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_valid;
    logic              load_ready;
    logic [DATA_W-1:0] load_data;
    logic              load_last;
    logic              load_done;
    logic              fetch_req_valid;
    logic              fetch_req_ready;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_flush;
    logic              fetch_rsp_valid;
    logic              fetch_rsp_ready;
    logic [DATA_W-1:0] fetch_inst;
    logic              fetch_fault;

    int errors = 0;
    int checks = 0;
    int rsp_cnt = 0;
    logic [32:0] exp_q[$];

    inst_mem_ctrl #(
        .DATA_W   (DATA_W),
        .DEPTH    (DEPTH),
        .ADDR_W   (ADDR_W),
        .NOP_INST (NOP)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_valid      (load_valid),
        .load_ready      (load_ready),
        .load_data       (load_data),
        .load_last       (load_last),
        .load_done       (load_done),
        .fetch_req_valid (fetch_req_valid),
        .fetch_req_ready (fetch_req_ready),
        .fetch_addr      (fetch_addr),
        .fetch_flush     (fetch_flush),
        .fetch_rsp_valid (fetch_rsp_valid),
        .fetch_rsp_ready (fetch_rsp_ready),
        .fetch_inst      (fetch_inst),
        .fetch_fault     (fetch_fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard monitor: a response transfers on the next rising edge.
    always @(negedge clk) begin
        if (rst_n && fetch_rsp_valid && fetch_rsp_ready) begin
            rsp_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_rsp", 64'({fetch_inst, fetch_fault}), 64'hDEAD);
            end else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                check("rsp_inst", 64'(fetch_inst), 64'(e[32:1]));
                check("rsp_fault", 64'(fetch_fault), 64'(e[0]));
            end
        end
    end

    // Reset with inputs idle; released away from the clock edge.
    task automatic do_reset();
        rst_n           = 1'b0;
        load_valid      = 1'b0;
        load_data       = '0;
        load_last       = 1'b0;
        fetch_req_valid = 1'b0;
        fetch_addr      = '0;
        fetch_flush     = 1'b0;
        fetch_rsp_ready = 1'b1;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Stream n words; use_last tags the final beat.
    task automatic load_image(input logic [31:0] words[$], input int n, input bit use_last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = words[i];
            load_last  = use_last && (i == n - 1);
            @(negedge clk);
            if (i == 0) check("load_ready_boot", 64'(load_ready), 64'd1);
            if (i == n - 1) check("load_done_before_last", 64'(load_done), 64'd0);
            @(posedge clk);
            #1;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
        @(negedge clk);
        if (use_last || n == int'(DEPTH)) begin
            check("load_done_after", 64'(load_done), 64'd1);
            check("load_ready_run", 64'(load_ready), 64'd0);
            check("req_ready_run", 64'(fetch_req_ready), 64'd1);
        end else begin
            check("load_done_partial", 64'(load_done), 64'd0);
        end
        @(posedge clk);
        #1;
    endtask

    // Present a request until accepted; push its expected response.
    task automatic issue(input logic [31:0] a, input logic [31:0] ei, input logic ef);
        int n;
        n = 0;
        fetch_req_valid = 1'b1;
        fetch_addr      = a;
        @(negedge clk);
        while (!fetch_req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!fetch_req_ready) check("req_accept_timeout", 64'(fetch_req_ready), 64'd1);
        else exp_q.push_back({ei, ef});
        @(posedge clk);
        #1 fetch_req_valid = 1'b0;
    endtask

    logic [31:0] img1[$];
    logic [31:0] bad[$];
    logic [31:0] big[$];
    int base;

    initial begin
        img1 = '{32'h0050_0093, 32'h0010_0113, 32'h0020_81B3, 32'h0000_0013};
        bad  = '{32'hBAD0_0000, 32'hBAD0_0001};
        for (int i = 0; i < int'(DEPTH); i++) big.push_back(32'hA000_0000 + 32'(i));

        // Reset values.
        do_reset();
        @(negedge clk);
        check("rst_load_ready", 64'(load_ready), 64'd1);
        check("rst_load_done", 64'(load_done), 64'd0);
        check("rst_rsp_valid", 64'(fetch_rsp_valid), 64'd0);
        check("rst_inst", 64'(fetch_inst), 64'(NOP));
        check("rst_fault", 64'(fetch_fault), 64'd0);
        check("rst_req_ready", 64'(fetch_req_ready), 64'd0);
        @(posedge clk);
        #1;

        // Four-word image with load_last, back-to-back fetches.
        load_image(img1, 4, 1'b1);
        base = rsp_cnt;
        issue(32'h0, img1[0], 1'b0);
        issue(32'h4, img1[1], 1'b0);
        issue(32'h8, img1[2], 1'b0);
        issue(32'hC, img1[3], 1'b0);
        @(posedge clk);
        #1 check("b2b_count", 64'(rsp_cnt - base), 64'd4);

        // Misaligned and out-of-range.
        issue(32'h6, NOP, 1'b1);
        issue(32'h400, NOP, 1'b0);
        issue(32'h3FC + 32'h1, NOP, 1'b1);
        @(posedge clk);
        #1;

        // Backpressure hold for 3 cycles, then release with a new request.
        fetch_rsp_ready = 1'b0;
        issue(32'h4, 32'h0010_0113, 1'b0);
        fetch_req_valid = 1'b1;
        fetch_addr      = 32'h8;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hold_req_ready", 64'(fetch_req_ready), 64'd0);
            check("hold_valid", 64'(fetch_rsp_valid), 64'd1);
            check("hold_inst", 64'(fetch_inst), 64'h0010_0113);
        end
        @(posedge clk);
        #1 fetch_rsp_ready = 1'b1;
        issue(32'h8, 32'h0020_81B3, 1'b0);
        check("rsp_latency_valid", 64'(fetch_rsp_valid), 64'd1);
        @(posedge clk);
        #1;

        // Flush with a pending response and a same-cycle request.
        fetch_rsp_ready = 1'b0;
        issue(32'h8, 32'h0020_81B3, 1'b0);
        fetch_flush     = 1'b1;
        fetch_req_valid = 1'b1;
        fetch_addr      = 32'h0;
        @(posedge clk);
        #1;
        fetch_flush     = 1'b0;
        fetch_req_valid = 1'b0;
        void'(exp_q.pop_back());
        @(negedge clk);
        check("flush_clears", 64'(fetch_rsp_valid), 64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("flush_no_accept", 64'(fetch_rsp_valid), 64'd0);
        @(posedge clk);
        #1 fetch_rsp_ready = 1'b1;
        issue(32'h0, 32'h0050_0093, 1'b0);
        @(posedge clk);
        #1;

        // Reset with a response pending drops it.
        fetch_rsp_ready = 1'b0;
        issue(32'hC, 32'h0000_0013, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_fetch_valid", 64'(fetch_rsp_valid), 64'd0);
        do_reset();

        // Reset after 2 of 4 beats, then full reload.
        load_image(bad, 2, 1'b0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_load_ready", 64'(load_ready), 64'd1);
        check("rst_mid_load_done", 64'(load_done), 64'd0);
        check("rst_mid_load_valid", 64'(fetch_rsp_valid), 64'd0);
        do_reset();
        load_image(img1, 4, 1'b1);
        issue(32'h0, img1[0], 1'b0);
        issue(32'h4, img1[1], 1'b0);
        issue(32'h8, img1[2], 1'b0);
        issue(32'hC, img1[3], 1'b0);
        @(posedge clk);
        #1;

        // Full-depth image without load_last; extra beat is refused.
        do_reset();
        load_image(big, int'(DEPTH), 1'b0);
        load_valid = 1'b1;
        load_data  = 32'hFFFF_FFFF;
        @(negedge clk);
        check("extra_beat_ready", 64'(load_ready), 64'd0);
        @(posedge clk);
        #1 load_valid = 1'b0;
        issue(32'h0, 32'hA000_0000, 1'b0);
        issue((DEPTH - 1) * 4, 32'hA000_0000 + 32'(DEPTH - 1), 1'b0);
        issue(DEPTH * 4, NOP, 1'b0);
        issue(32'h6, NOP, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
